cpu_sequencer: RTL
==================

# cpu_sequencer

Run-control and phase sequencer for the 8-phase accumulator CPU. It generates the `phase` value consumed by `cpu_controller`, observes the controller's `halt` output, and implements run / single-step / stop-at-boundary control. It also keeps a retired-instruction counter. It sits directly upstream of `cpu_controller` and replaces any free-running phase counter.

## Interface
Parameters:
- `PHASE_W`, 8, width of `phase`; matches the controller's `max_phase`.
- `NUM_PHASES`, 8, phases per instruction; legal value is 8 only.
- `CNT_W`, 16, width of `instr_count`.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `run_req`  in  1  one-cycle request: start continuous execution.
- `step_req`  in  1  one-cycle request: execute exactly one instruction.
- `stop_req`  in  1  one-cycle request: stop at the next instruction boundary.
- `halt`  in  1  from `cpu_controller`; meaningful only when `phase`==4.
- `phase`  out  PHASE_W  binary phase value 0..7.
- `busy`  out  1  high in RUN or STEP.
- `halted`  out  1  high in HALTED.
- `instr_done`  out  1  high during the last phase (7) of an active instruction.
- `instr_count`  out  CNT_W  count of instructions completed through phase 7.

## Operation
- FSM states: IDLE, RUN, STEP, HALTED.
- Active means state RUN or STEP. In IDLE and HALTED, `phase` is held at 0. At phase 0 the controller drives only `sel`, so holding 0 is side-effect free.
- In an active state, `phase` increments by 1 each cycle and wraps 7→0.
- IDLE:
  - `run_req` → RUN.
  - else `step_req` → STEP.
  - `run_req` wins if both are high.
  - `stop_req` is ignored.
- RUN:
  - `stop_req` sets `stop_pending`. It is sampled in any RUN cycle, including the phase-7 cycle.
  - At the 7→0 edge: if `stop_pending` (or `stop_req` in that cycle), go to IDLE and clear `stop_pending`; otherwise stay in RUN.
- STEP: at the 7→0 edge, go to IDLE. `stop_req` has no additional effect; `stop_pending` is cleared on exit.
- Halt:
  - Condition: active state, `phase`==4, and `halt`==1.
  - At the next edge: go to HALTED, set `phase` to 0, clear `stop_pending`.
  - `instr_count` is not incremented and `instr_done` is not asserted.
  - Halt wins over a pending stop.
- HALTED:
  - `run_req` → RUN.
  - else `step_req` → STEP.
  - The controller has already incremented the PC in phase 4, so resuming executes the next instruction.
- `run_req` and `step_req` are ignored while active.
- `instr_count` increments at every 7→0 edge in an active state and wraps modulo 2^CNT_W.
- `instr_done` = active && `phase`==7 (combinational from registered state).

## Timing
- Reset values: state IDLE, `phase` 0, `busy` 0, `halted` 0, `instr_done` 0, `instr_count` 0, `stop_pending` 0.
- Reset mid-instruction takes effect immediately (asynchronously) and abandons the instruction.
- Request-to-first-active-phase:
  - `run_req` sampled at edge k makes state RUN after k. `phase` is still 0 in that cycle, which is the first instruction's phase 0.
  - `phase`==1 after edge k+1.
- One instruction occupies exactly 8 active cycles. No bubbles occur between consecutive instructions in RUN.
- Stop latency: state is IDLE on the first edge where `phase` goes 7→0 after `stop_req` is sampled.
- Halt latency: `halted`=1 one cycle after the phase-4 cycle. `phase` reads 0 in that same cycle.
- `busy`, `halted`, and `instr_count` are registered.

## Structure
- Shared definitions file `cpu_defs.vh`: state encodings `ST_IDLE`/`ST_RUN`/`ST_STEP`/`ST_HALTED`, `PH_HALT`=4, `PH_LAST`=7. The controller's phase constants move there as well.
- One sub-module, `phase_counter`: modulo-NUM_PHASES counter with `en`, synchronous `clr`, async `rst`, and a `wrap` flag for `phase`==NUM_PHASES-1.
- The FSM, stop latch, and instruction counter live in `cpu_sequencer`.

## Test plan
- Reset, then `run_req` pulse, `halt`=0 for 40 cycles:
  - `phase` sequence 0,0,1..7,0,1..
  - `instr_count`=4 after 4 wraps.
  - `instr_done` high exactly 4 single cycles.
- IDLE, `step_req` → 8 active cycles, then IDLE:
  - `instr_count`=1, `busy` drops after the 7→0 edge.
  - A `run_req` asserted at phase 3 is ignored.
- RUN, `stop_req` at phase 2 of instruction 3 → IDLE after that instruction's phase 7; `instr_count`=3.
- RUN, `halt`=1 at phase 4 of instruction 2:
  - next cycle `halted`=1, `phase`=0, `instr_count`=1.
  - `run_req` → RUN resumes and `halted`=0.
- Same phase-4 cycle with `stop_pending` set and `halt`=1 → HALTED (not IDLE); a subsequent `step_req` runs one instruction then goes to IDLE.
- Assert `rst` asynchronously at phase 5 in RUN:
  - outputs go to reset values before the next edge.
  - `instr_count`=0.
  - Preload near wrap (CNT_W=4, 16 instructions) → `instr_count` wraps 15→0.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// cpu_sequencer_pkg
//
// Shared definitions for the accumulator CPU run-control path: sequencer FSM
// state encodings and the phase numbers that matter to the sequencer and the
// controller (PH_HALT is when the controller reports halt, PH_LAST closes an
// instruction).
// -----------------------------------------------------------------------------
package cpu_sequencer_pkg;

  // Sequencer FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_STEP   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  // Phase numbers shared with cpu_controller
  localparam int PH_HALT = 4;
  localparam int PH_LAST = 7;

  // RUN and STEP are the only states in which the phase advances
  function automatic logic is_active(input logic [1:0] st);
    return (st == ST_RUN) || (st == ST_STEP);
  endfunction

endpackage

// File: rtl/cpu_sequencer_phase_counter.sv
// -----------------------------------------------------------------------------
// phase_counter
//
// Modulo-NUM_PHASES binary counter producing the instruction phase.
//
// Ports:
//   clk    in   clock, counts on posedge
//   rst    in   asynchronous active-high reset, clears the count
//   en     in   advance the count by one (wraps NUM_PHASES-1 -> 0)
//   clr    in   synchronous clear, takes priority over en
//   phase  out  current count
//   wrap   out  high while phase == NUM_PHASES-1
// -----------------------------------------------------------------------------
module phase_counter #(
  parameter int PHASE_W    = 8,
  parameter int NUM_PHASES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  output logic [PHASE_W-1:0] phase,
  output logic               wrap
);

  logic [PHASE_W-1:0] count_q;
  logic [PHASE_W-1:0] count_d;

  assign wrap  = (count_q == PHASE_W'(NUM_PHASES - 1));
  assign phase = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = wrap ? '0 : count_q + PHASE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//
// Run-control and phase sequencer for the 8-phase accumulator CPU. Generates
// the phase consumed by cpu_controller, watches its halt output, and provides
// run / single-step / stop-at-instruction-boundary control plus a retired
// instruction counter.
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   run_req      in   one-cycle pulse: start continuous execution
//   step_req     in   one-cycle pulse: execute exactly one instruction
//   stop_req     in   one-cycle pulse: stop at the next instruction boundary
//   halt         in   controller halt flag, only looked at in phase 4
//   phase        out  binary phase 0..7, held at 0 when not active
//   busy         out  registered, high in RUN or STEP
//   halted       out  registered, high in HALTED
//   instr_done   out  high during phase 7 of an active instruction
//   instr_count  out  registered count of instructions completed through 7
// -----------------------------------------------------------------------------
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int PHASE_W    = 8,
  parameter int NUM_PHASES = 8,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_req,
  input  logic               step_req,
  input  logic               stop_req,
  input  logic               halt,
  output logic [PHASE_W-1:0] phase,
  output logic               busy,
  output logic               halted,
  output logic               instr_done,
  output logic [CNT_W-1:0]   instr_count
);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             stop_pending_q;
  logic             stop_pending_d;
  logic [CNT_W-1:0] instr_count_q;
  logic [CNT_W-1:0] instr_count_d;
  logic             busy_q;
  logic             busy_d;
  logic             halted_q;
  logic             halted_d;

  logic             active;
  logic             wrap;
  logic             halt_hit;
  logic             last_phase;

  assign active     = is_active(state_q);
  assign halt_hit   = active && (phase == PHASE_W'(PH_HALT)) && halt;
  assign last_phase = active && wrap;

  // The counter only moves while active; on halt it is forced back to 0 so
  // HALTED presents phase 0 immediately. Leaving RUN/STEP normally happens on
  // the 7->0 wrap, so phase is already 0 in IDLE without an explicit clear.
  phase_counter #(
    .PHASE_W    (PHASE_W),
    .NUM_PHASES (NUM_PHASES)
  ) u_phase_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (active),
    .clr   (halt_hit),
    .phase (phase),
    .wrap  (wrap)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_HALTED: begin
        // run_req takes priority over step_req; stop_req means nothing here
        if (run_req) begin
          state_d = ST_RUN;
        end else if (step_req) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        // Halt beats a pending stop; stop_req in the phase-7 cycle itself
        // still stops at this boundary.
        if (halt_hit) begin
          state_d = ST_HALTED;
        end else if (last_phase && (stop_pending_q || stop_req)) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (halt_hit) begin
          state_d = ST_HALTED;
        end else if (last_phase) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The stop latch only lives inside RUN and is dropped at every exit
  // (boundary or halt), so it never leaks into the next run.
  always_comb begin
    stop_pending_d = 1'b0;
    if ((state_q == ST_RUN) && !halt_hit && !last_phase) begin
      stop_pending_d = stop_pending_q || stop_req;
    end
  end

  // A halted instruction never reaches phase 7, so it is not counted.
  always_comb begin
    instr_count_d = instr_count_q;
    if (last_phase) begin
      instr_count_d = instr_count_q + CNT_W'(1);
    end
  end

  // Status flags are registered versions of the next state so they line up
  // with state_q without a decode after the flop.
  always_comb begin
    busy_d   = is_active(state_d);
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      stop_pending_q <= 1'b0;
      instr_count_q  <= '0;
      busy_q         <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      stop_pending_q <= stop_pending_d;
      instr_count_q  <= instr_count_d;
      busy_q         <= busy_d;
      halted_q       <= halted_d;
    end
  end

  assign busy        = busy_q;
  assign halted      = halted_q;
  assign instr_count = instr_count_q;
  assign instr_done  = active && (phase == PHASE_W'(PH_LAST));

endmodule
